// File: rtl/alu_req_master.sv
// alu_req_master
//   Initiator for a sequential ALU with an en/done interface. Commands arrive
//   over a valid/ready handshake and each is launched on the ALU with a
//   one-cycle en pulse. The result is captured on the rising edge of done and
//   returned over a second valid/ready handshake. Only one op is in flight at
//   any time.
//
//   Handshake semantics (both channels): a transfer happens on a rising clk
//   edge where valid and ready are both 1. A producer holds valid and payload
//   stable until that transfer. cmd_ready depends on state only, and
//   rsp_valid/rsp_* come from registers.
//
//   Optional feature: define ALU_REQ_TIMEOUT_EN to abort an op whose done
//   has not risen within TIMEOUT_CYC WAIT cycles. The aborted op is reported
//   with rsp_err=1 and rsp_res=0. Without the macro no counter is built and
//   rsp_err is tied to 0.
//
// Ports
//   clk, nrst                 clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready       command handshake
//   cmd_opA/opB/opcode        command payload
//   alu_opA/opB/opcode        operands held toward the ALU
//   alu_en                    one-cycle start pulse
//   alu_res, alu_done         ALU result and completion flag
//   rsp_valid/rsp_ready       response handshake
//   rsp_res/opcode/err        response payload
//   busy                      1 in any state other than IDLE
//   op_count                  responses handed off, wraps at 2^CNT_W
//   fsm_state                 debug view of the FSM state encoding
module alu_req_master #(
  parameter int TIMEOUT_CYC = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [15:0]      cmd_opA,
  input  logic [15:0]      cmd_opB,
  input  logic [1:0]       cmd_opcode,
  output logic [15:0]      alu_opA,
  output logic [15:0]      alu_opB,
  output logic [1:0]       alu_opcode,
  output logic             alu_en,
  input  logic [31:0]      alu_res,
  input  logic             alu_done,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_res,
  output logic [1:0]       rsp_opcode,
  output logic             rsp_err,
  output logic             busy,
  output logic [CNT_W-1:0] op_count,
  output logic [1:0]       fsm_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t state, state_next;
  logic   done_q;
  logic   done_rise;
  logic   expire;
  logic   cap_cmd;
  logic   cap_rsp;
  logic   cap_timeout;

  // Only a fresh edge of done completes an op; a level left high by the
  // previous op is not mistaken for the new result.
  assign done_rise = alu_done & ~done_q;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign fsm_state = state;

`ifdef ALU_REQ_TIMEOUT_EN
  localparam int TO_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
  logic [TO_W-1:0] to_cnt;
  logic            rsp_err_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      to_cnt <= '0;
    end else if (state == ISSUE) begin
      to_cnt <= '0;
    end else if (state == WAIT) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  // The count after this WAIT cycle's increment reaches TIMEOUT_CYC.
  assign expire  = (state == WAIT) && (to_cnt == TO_W'(TIMEOUT_CYC - 1));
  assign rsp_err = rsp_err_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYC == 0);
  assign expire         = 1'b0;
  assign rsp_err        = 1'b0;
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state  <= IDLE;
      done_q <= 1'b0;
    end else begin
      state  <= state_next;
      done_q <= alu_done;
    end
  end

  always_comb begin
    state_next  = state;
    cap_cmd     = 1'b0;
    cap_rsp     = 1'b0;
    cap_timeout = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          cap_cmd    = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: state_next = WAIT;
      WAIT: begin
        // A done edge in the expiry cycle takes priority over the abort.
        if (done_rise) begin
          cap_rsp    = 1'b1;
          state_next = RESP;
        end else if (expire) begin
          cap_timeout = 1'b1;
          state_next  = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      alu_opA    <= '0;
      alu_opB    <= '0;
      alu_opcode <= '0;
      alu_en     <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_res    <= '0;
      rsp_opcode <= '0;
      op_count   <= '0;
`ifdef ALU_REQ_TIMEOUT_EN
      rsp_err_q  <= 1'b0;
`endif
    end else begin
      // Registered from next state so both line up with ISSUE / RESP.
      alu_en    <= (state_next == ISSUE);
      rsp_valid <= (state_next == RESP);
      if (cap_cmd) begin
        alu_opA    <= cmd_opA;
        alu_opB    <= cmd_opB;
        alu_opcode <= cmd_opcode;
      end
      if (cap_rsp) begin
        rsp_res    <= alu_res;
        rsp_opcode <= alu_opcode;
`ifdef ALU_REQ_TIMEOUT_EN
        rsp_err_q  <= 1'b0;
`endif
      end
      if (cap_timeout) begin
        rsp_res    <= '0;
        rsp_opcode <= alu_opcode;
`ifdef ALU_REQ_TIMEOUT_EN
        rsp_err_q  <= 1'b1;
`endif
      end
      if ((state == RESP) && rsp_ready) begin
        op_count <= op_count + 1'b1;
      end
    end
  end

endmodule

// File: doc/alu_req_master.md
Name: alu_req_master

Overview:
- Initiator for the sequential ALU's en/done interface.
- Accepts operand/opcode commands from an upstream producer over a valid/ready handshake and launches each one on the ALU with a single-cycle en pulse.
- Holds operands stable while the ALU runs, captures res on done, and returns the result downstream over a second valid/ready handshake.
- Serialises all ALU traffic so that only one operation is in flight at a time.

Parameters:
- TIMEOUT_CYC, 64: maximum cycles from en pulse to done rising edge before the op is aborted (used only with ALU_REQ_TIMEOUT_EN).
- CNT_W, 16: width of the completed-operation counter.

Ports:
- clk  in  1  system clock, rising edge.
- nrst  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  upstream command valid.
- cmd_ready  out  1  block can accept a command.
- cmd_opA  in  16  operand A.
- cmd_opB  in  16  operand B.
- cmd_opcode  in  2  ALU opcode.
- alu_opA  out  16  operand A to ALU.
- alu_opB  out  16  operand B to ALU.
- alu_opcode  out  2  opcode to ALU.
- alu_en  out  1  start pulse to ALU.
- alu_res  in  32  ALU result.
- alu_done  in  1  ALU completion flag.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  downstream accepts response.
- rsp_res  out  32  captured result.
- rsp_opcode  out  2  opcode of the completed op.
- rsp_err  out  1  op aborted by timeout.
- busy  out  1  high in any state other than IDLE.
- op_count  out  CNT_W  count of responses handed off.

Behaviour:
- Reset: single clock clk; asynchronous active-low reset nrst. While nrst=0, every output register is 0: alu_opA, alu_opB, alu_opcode, alu_en, rsp_res, rsp_opcode, rsp_err, rsp_valid, op_count, and the done_q history. State forced to IDLE.
  - Asserting nrst mid-operation abandons the op; no response is produced.
- cmd_ready is 1 only in IDLE and is combinational from state.
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE: when cmd_valid=1, register cmd_opA/opB/opcode into alu_opA/opB/opcode and go to ISSUE. That cycle is the handshake.
  - ISSUE: alu_en=1 for exactly this one cycle; clear the timeout counter; go to WAIT.
  - WAIT: alu_en=0. done_rise = alu_done & ~done_q, where done_q is alu_done registered every cycle.
    - On done_rise: capture alu_res into rsp_res, alu_opcode into rsp_opcode, set rsp_err=0, go to RESP.
    - A level-high alu_done left over from a previous op is ignored; only a rising edge counts.
  - RESP: rsp_valid=1. When rsp_ready=1, the handshake completes: op_count increments (wraps modulo 2^CNT_W), rsp_valid drops next cycle, go to IDLE.
    - rsp_res, rsp_opcode and rsp_err stay stable while rsp_valid=1 and rsp_ready=0.
- alu_opA/opB/opcode hold their value from capture until the next command is accepted; they never change during ISSUE or WAIT.
- Latency: command handshake at cycle t gives alu_en at t+1. A done rising edge at cycle d gives rsp_valid=1 at d+1.
  - Minimum command-to-rsp_valid latency is 3 cycles plus the ALU latency.
- Throughput: one op per (ALU latency + 4) cycles when rsp_ready is held at 1. No new command is accepted while in RESP.
- done_rise during ISSUE (same cycle as en) is ignored.
- cmd_valid and input changes outside IDLE have no effect.

Optional Feature:
- Macro: ALU_REQ_TIMEOUT_EN.
- When defined:
  - An 8-bit-minimum counter increments each WAIT cycle.
  - If it reaches TIMEOUT_CYC with no done_rise, go to RESP with rsp_res=32'h0, rsp_opcode=alu_opcode, rsp_err=1.
  - A done_rise in the same cycle as expiry wins: normal capture, rsp_err=0.
- When undefined: no counter is built, WAIT lasts indefinitely, and rsp_err is constant 0.

Test Plan:
- The bench ALU model raises done 5 cycles after en and leaves it high until the next en.
- Reset: nrst=0 mid-WAIT -> all outputs 0 and state IDLE immediately; after release, cmd_ready=1 and no rsp_valid.
- Single op: cmd opA=16'h0003, opB=16'h0004, opcode=2'b10; model res=32'h0000000C -> exactly one alu_en pulse one cycle after handshake; rsp_valid 1 cycle after done rise with rsp_res=32'h0000000C, rsp_opcode=2'b10, rsp_err=0; op_count=1.
- Back-pressure: hold rsp_ready=0 for 10 cycles -> rsp_valid and rsp_res stable, cmd_ready=0 and cmd ignored; release -> op_count increments once.
- Stale done: model keeps done=1 between ops; issue second op with opA=16'hFFFF, opB=16'h0001 -> no early capture; rsp waits for the new done rising edge.
- Timeout (macro on, TIMEOUT_CYC=8): model never raises done -> rsp_valid 9 cycles after en with rsp_err=1, rsp_res=0. Macro off -> rsp_valid never asserts and busy stays 1.
- Counter wrap (CNT_W=4): 17 back-to-back ops with rsp_ready=1 -> op_count reads 1.
